// File: rtl/state_timer.sv
// rtl/state_timer.sv - per-state ms countdown timer with writable duration table (optional STATE_TIMER_PAUSE_EN)
module state_timer #(
    parameter int STATE_W  = 4,
    parameter int T_W      = 19,
    parameter int PRESCALE = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] present_state,
    input  logic               restart,
    input  logic               pause,
    input  logic               wr_en,
    input  logic [STATE_W-1:0] wr_addr,
    input  logic [T_W-1:0]     wr_data,
    output logic [T_W-1:0]     t,
    output logic [T_W-1:0]     remaining,
    output logic               running,
    output logic               expired
);

    localparam int DEPTH = 2 ** STATE_W;
    localparam int PW    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [T_W-1:0]     tbl [DEPTH];
    logic [STATE_W-1:0] state_q;
    logic [PW-1:0]      presc;
    logic               hold;
    logic               state_change;
    logic [T_W-1:0]     load_val;

    // Power-on durations used by the train controller's timed states.
    function automatic logic [T_W-1:0] default_entry(input int idx);
        case (idx)
            3:       default_entry = T_W'(2000);
            4:       default_entry = T_W'(1000);
            5:       default_entry = T_W'(2000);
            default: default_entry = '0;
        endcase
    endfunction

`ifdef STATE_TIMER_PAUSE_EN
    assign hold = pause;
`else
    // Pause is accepted on the port but has no effect in this build.
    assign hold = pause & 1'b0;
`endif

    assign state_change = (present_state != state_q);
    // Table read happens before any same-edge write lands, so a reload sees the old entry.
    assign load_val     = state_change ? tbl[present_state] : tbl[state_q];

    // Duration table: defaults on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= default_entry(i);
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    // Reload on state change or restart, otherwise run the ms countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            presc     <= '0;
            t         <= '0;
            remaining <= '0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (state_change || restart) begin
                state_q   <= present_state;
                t         <= load_val;
                remaining <= load_val;
                presc     <= '0;
                running   <= (load_val != '0);
            end else if (running && !hold) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (remaining <= T_W'(1)) begin
                        remaining <= '0;
                        running   <= 1'b0;
                        expired   <= 1'b1;
                    end else begin
                        remaining <= remaining - T_W'(1);
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_state_timer.sv
// tb/tb_state_timer.sv - directed self-checking bench for state_timer
module tb_state_timer;

    localparam int STATE_W  = 4;
    localparam int T_W      = 19;
    localparam int PRESCALE = 4;

    logic               clk;
    logic               rst_n;
    logic [STATE_W-1:0] present_state;
    logic               restart;
    logic               pause;
    logic               wr_en;
    logic [STATE_W-1:0] wr_addr;
    logic [T_W-1:0]     wr_data;
    logic [T_W-1:0]     t;
    logic [T_W-1:0]     remaining;
    logic               running;
    logic               expired;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    state_timer #(
        .STATE_W  (STATE_W),
        .T_W      (T_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .present_state (present_state),
        .restart       (restart),
        .pause         (pause),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .t             (t),
        .remaining     (remaining),
        .running       (running),
        .expired       (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (expired) cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; present_state = '0; restart = 1'b0; pause = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step(2);
        check("rst_t", t, 0);
        check("rst_remaining", remaining, 0);
        check("rst_running", running, 0);
        check("rst_expired", expired, 0);
        rst_n = 1'b1;
        step(1);

        // state 3: 2000 ms = 8000 countdown cycles
        present_state = 4'd3;
        step(1);
        check("s3_t", t, 2000);
        check("s3_remaining", remaining, 2000);
        check("s3_running", running, 1);
        step(4);
        check("s3_after_1ms", remaining, 1999);
        step(7995);
        check("s3_last_ms", remaining, 1);
        check("s3_no_early_exp", expired, 0);
        step(1);
        check("s3_expired", expired, 1);
        check("s3_done_running", running, 0);
        check("s3_done_remaining", remaining, 0);
        step(1);
        check("s3_pulse_one_cycle", expired, 0);

        // state 5 partially run, then switch to 4
        present_state = 4'd5;
        step(1);
        check("s5_load", remaining, 2000);
        step(2000);
        check("s5_remaining_1500", remaining, 1500);
        present_state = 4'd4;
        step(1);
        check("s4_t", t, 1000);
        check("s4_remaining", remaining, 1000);
        check("s4_no_exp", expired, 0);
        step(3);
        check("s4_presc_cleared", remaining, 1000);
        step(1);
        check("s4_first_ms", remaining, 999);

        // restart in state 3 after 10 ms
        present_state = 4'd3;
        step(1);
        step(40);
        check("rs_remaining_1990", remaining, 1990);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("rs_reload", remaining, 2000);
        step(3);
        check("rs_presc_cleared", remaining, 2000);
        step(1);
        check("rs_first_ms", remaining, 1999);
        restart = 1'b1;
        present_state = 4'd4;
        step(1);
        restart = 1'b0;
        check("rs_chg_remaining", remaining, 1000);
        check("rs_chg_t", t, 1000);

        // entry 4 = 3 ms, expiry after 12 countdown cycles, no repeat
        present_state = 4'd0;
        step(1);
        check("s0_running", running, 0);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 19'd3;
        step(1);
        wr_en = 1'b0;
        check("wr_no_effect_t", t, 0);
        present_state = 4'd4;
        step(1);
        check("w4_t", t, 3);
        step(11);
        check("w4_no_early_exp", expired, 0);
        check("w4_last_ms", remaining, 1);
        step(1);
        check("w4_expired", expired, 1);
        count_pulses(100, pulses);
        check("w4_no_repeat", pulses, 0);

        // write to entry 3 on the reload edge: old value loaded, restart picks new
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 19'd7;
        present_state = 4'd3;
        step(1);
        wr_en = 1'b0;
        check("rbw_t_old", t, 2000);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("rbw_t_new", t, 7);
        check("rbw_remaining_new", remaining, 7);

        // untimed state 0
        present_state = 4'd0;
        step(1);
        check("u0_running", running, 0);
        check("u0_t", t, 0);
        count_pulses(50, pulses);
        check("u0_no_pulse", pulses, 0);

        // pause: 20 paused cycles mid-countdown in state 3 (7 ms)
        present_state = 4'd3;
        step(1);
        check("p_load", remaining, 7);
        step(8);
        check("p_before", remaining, 5);
        pause = 1'b1;
        step(20);
        pause = 1'b0;
`ifdef STATE_TIMER_PAUSE_EN
        check("p_frozen", remaining, 5);
        check("p_running_held", running, 1);
        check("p_no_exp", expired, 0);
        step(19);
        check("p_last_ms", remaining, 1);
        check("p_no_early_exp", expired, 0);
        step(1);
        check("p_delayed_exp", expired, 1);
`else
        check("p_ignored_exp", expired, 1);
        check("p_ignored_remaining", remaining, 0);
`endif

        // async reset mid-count restores outputs and table defaults
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(5);
        check("ar_running_pre", running, 1);
        rst_n = 1'b0;
        #1;
        check("ar_t", t, 0);
        check("ar_remaining", remaining, 0);
        check("ar_running", running, 0);
        check("ar_expired", expired, 0);
        rst_n = 1'b1;
        step(1);
        check("ar_tbl3_default", t, 2000);
        present_state = 4'd4;
        step(1);
        check("ar_tbl4_default", t, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
